// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin grant, access checks,
// one memory access per grant. Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [2:0]            funct30,
    output logic                  ack0,
    output logic                  err0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [2:0]            funct31,
    output logic                  ack1,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  win;
    logic [DATA_WIDTH-1:0] access_rdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign win = ~req0;
`else
    logic last_grant_q, last_grant_d;
    // On a tie the port that did not win last time gets the grant.
    assign win = (req0 && req1) ? ~last_grant_q : req1;
`endif

    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lsb);
        logic illegal;
        logic misaligned;
        case (f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = we;
            default:                illegal = 1'b1;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && lsb[0]) || ((f3[1:0] == 2'b10) && (lsb != 2'b00));
        return illegal || misaligned;
    endfunction

    assign access_rdata = (err_q || we_q) ? '0 : mem_rd_data;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    grant_d  = win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_grant_d = win;
`endif
                    we_d     = win ? we1 : we0;
                    addr_d   = win ? addr1 : addr0;
                    wdata_d  = win ? wdata1 : wdata0;
                    funct3_d = win ? funct31 : funct30;
                    err_d    = win ? access_err(we1, funct31, addr1[1:0])
                                   : access_err(we0, funct30, addr0[1:0]);
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (grant_q) begin
                    rdata1_d = access_rdata;
                end else begin
                    rdata0_d = access_rdata;
                end
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign ack0   = (state_q == StResp) && !grant_q;
    assign ack1   = (state_q == StResp) && grant_q;
    assign err0   = ack0 && err_q;
    assign err1   = ack1 && err_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    // Reset gates the strobe combinationally so an interrupted store never lands.
    assign mem_wr_en   = (state_q == StAccess) && we_q && !err_q && !reset;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_funct3  = funct3_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-addressed memory model plus a response scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [2:0]  funct30, funct31;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic [2:0]  mem_funct3;
    logic        mem_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] held0, held1;
    bit          rearm0;
    logic [31:0] rearm_addr;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .funct30(funct30),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .funct31(funct31),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data)
    );

    // Little-endian memory model with width/sign handling on the read side.
    logic [7:0] mem [0:255];
    logic [7:0] ra, rb0, rb1, rb2, rb3;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_wr_en) begin
            case (mem_funct3)
                3'b000: mem[mem_addr[7:0]] <= mem_wr_data[7:0];
                3'b001: begin
                    mem[mem_addr[7:0]]         <= mem_wr_data[7:0];
                    mem[mem_addr[7:0] + 8'd1]  <= mem_wr_data[15:8];
                end
                3'b010: begin
                    mem[mem_addr[7:0]]         <= mem_wr_data[7:0];
                    mem[mem_addr[7:0] + 8'd1]  <= mem_wr_data[15:8];
                    mem[mem_addr[7:0] + 8'd2]  <= mem_wr_data[23:16];
                    mem[mem_addr[7:0] + 8'd3]  <= mem_wr_data[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ra  = mem_addr[7:0];
        rb0 = mem[ra];
        rb1 = mem[ra + 8'd1];
        rb2 = mem[ra + 8'd2];
        rb3 = mem[ra + 8'd3];
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{rb0[7]}}, rb0};
            3'b001:  mem_rd_data = {{16{rb1[7]}}, rb1, rb0};
            3'b010:  mem_rd_data = {rb3, rb2, rb1, rb0};
            3'b100:  mem_rd_data = {24'h0, rb0};
            3'b101:  mem_rd_data = {16'h0, rb1, rb0};
            default: mem_rd_data = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        if (!p) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; funct30 = f;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; funct31 = f;
        end
    endtask

    task automatic push(input bit p, input bit err, input logic [31:0] rd, input int cyc);
        exp_t e;
        e.port = p; e.err = err; e.rdata = rd; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic handle_ack(input bit p, input int cyc);
        exp_t e;
        if (sb.size() == 0) begin
            chk($sformatf("unexpected_ack%0d", p), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ack_port", {31'd0, p}, {31'd0, e.port});
            chk($sformatf("ack_cycle%0d", p), cyc, e.cyc);
            chk($sformatf("err%0d", p), {31'd0, p ? err1 : err0}, {31'd0, e.err});
            chk($sformatf("rdata%0d", p), p ? rdata1 : rdata0, e.rdata);
        end
        if (p) begin
            held1 = rdata1;
            req1  = 1'b0;
        end else begin
            held0 = rdata0;
            if (rearm0) begin
                rearm0 = 1'b0;
                set_req(1'b0, 1'b0, rearm_addr, 32'h0, 3'b010);
            end else begin
                req0 = 1'b0;
            end
        end
    endtask

    // Runs cycles until the scoreboard drains, checking acks, held rdata and write strobes.
    task automatic go(input int exp_writes);
        int cyc = 0;
        int writes = 0;
        while (sb.size() > 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_wr_en) writes++;
            if (ack0) handle_ack(1'b0, cyc);
            else chk("rdata0_hold", rdata0, held0);
            if (ack1) handle_ack(1'b1, cyc);
            else chk("rdata1_hold", rdata1, held1);
        end
        if (sb.size() != 0) begin
            chk("ack_timeout", sb.size(), 32'd0);
            sb.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end
        chk("wr_strobes", writes, exp_writes);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit clr);
        reset   = 1'b1;
        mem_clr = clr;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_clr = 1'b0;
        held0 = 32'h0;
        held1 = 32'h0;
    endtask

    task automatic one(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit err, input logic [31:0] rd, input int wr);
        set_req(p, we, a, d, f);
        push(p, err, rd, 3);
        go(wr);
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; funct30 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; funct31 = 0;
        rearm0 = 1'b0; rearm_addr = 32'h0;
        do_reset(1'b1);

        @(negedge clk);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;

        // Store word then load it back.
        one(1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 3'b010, 1'b0, 32'h0, 1);
        one(1'b0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hCAFEBABE, 0);
        one(1'b1, 1'b1, 32'h14, 32'h0BADF00D, 3'b010, 1'b0, 32'h0, 1);

        // Tie after reset, then port 0 re-requests right after its ack.
        do_reset(1'b0);
        set_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
        set_req(1'b1, 1'b0, 32'h14, 32'h0, 3'b010);
        rearm0     = 1'b1;
        rearm_addr = 32'h14;
        push(1'b0, 1'b0, 32'hCAFEBABE, 3);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        push(1'b0, 1'b0, 32'h0BADF00D, 6);
        push(1'b1, 1'b0, 32'h0BADF00D, 9);
`else
        push(1'b1, 1'b0, 32'h0BADF00D, 6);
        push(1'b0, 1'b0, 32'h0BADF00D, 9);
`endif
        go(0);

        // Misaligned half store is rejected without touching memory.
        one(1'b1, 1'b1, 32'h13, 32'hFFFFFFFF, 3'b001, 1'b1, 32'h0, 0);
        one(1'b0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hCAFEBABE, 0);

        // Byte store, then signed/unsigned byte and half loads.
        one(1'b0, 1'b1, 32'h11, 32'h00000080, 3'b000, 1'b0, 32'h0, 1);
        one(1'b0, 1'b0, 32'h11, 32'h0, 3'b000, 1'b0, 32'hFFFFFF80, 0);
        one(1'b0, 1'b0, 32'h11, 32'h0, 3'b100, 1'b0, 32'h00000080, 0);
        one(1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 1'b0, 32'hFFFFCAFE, 0);
        one(1'b1, 1'b0, 32'h12, 32'h0, 3'b101, 1'b0, 32'h0000CAFE, 0);

        // Illegal codes and misaligned loads.
        one(1'b0, 1'b1, 32'h18, 32'h12345678, 3'b011, 1'b1, 32'h0, 0);
        one(1'b1, 1'b0, 32'h10, 32'h0, 3'b111, 1'b1, 32'h0, 0);
        one(1'b0, 1'b0, 32'h12, 32'h0, 3'b010, 1'b1, 32'h0, 0);
        one(1'b0, 1'b0, 32'h11, 32'h0, 3'b101, 1'b1, 32'h0, 0);
        one(1'b1, 1'b1, 32'h10, 32'h0, 3'b100, 1'b1, 32'h0, 0);
        one(1'b0, 1'b0, 32'h18, 32'h0, 3'b010, 1'b0, 32'h0, 0);

        // Reset during the ACCESS cycle of a store.
        one(1'b0, 1'b1, 32'h20, 32'h11111111, 3'b010, 1'b0, 32'h0, 1);
        set_req(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 3'b010);
        @(negedge clk);
        @(negedge clk);
        chk("access_wr_en", {31'd0, mem_wr_en}, 32'd1);
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        chk("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        held0 = 32'h0;
        held1 = 32'h0;
        @(negedge clk);
        chk("post_reset_ack0", {31'd0, ack0}, 32'd0);
        chk("post_reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        chk("post_reset_ack0_b", {31'd0, ack0}, 32'd0);
        @(posedge clk);
        #1;
        one(1'b0, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h11111111, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
